task_dispatcher: RTL and testbench

TASK_DISPATCHER -- requirements
Module: task_dispatcher

---
 rtl/task_dispatcher.sv | 163 ++++++++++++++++
 tb/tb_task_dispatcher.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/task_dispatcher.sv
// Task dispatcher: per-channel request latches feeding a round-robin
// arbiter and a single-executor IDLE/START/RUN sequencer with a
// saturating RUN-cycle timeout.

// One pending-request bit per channel.
module task_dispatcher_chan (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    input  logic dis_i,
    input  logic busy_i,
    input  logic grant_i,
    output logic pending_o
);
    logic pending_q, pending_d;

    // Disable wins, then grant consumes; new requests only land when idle.
    always_comb begin
        pending_d = pending_q;
        if (dis_i)
            pending_d = 1'b0;
        else if (grant_i)
            pending_d = 1'b0;
        else if (req_i && !busy_i)
            pending_d = 1'b1;
    end

    // Pending state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pending_q <= 1'b0;
        else          pending_q <= pending_d;
    end

    assign pending_o = pending_q;
endmodule

module task_dispatcher #(
    parameter  int CHANNELS      = 4,
    parameter  int TIMEOUT_WIDTH = 16,
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [CHANNELS-1:0]      task_req_i,
    input  logic [CHANNELS-1:0]      disable_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles_i,
    output logic [CHANNELS-1:0]      busy_o,
    output logic [CHANNELS-1:0]      task_done_o,
    output logic [CHANNELS-1:0]      task_timeout_o,
    output logic                     exec_start_o,
    output logic [CW-1:0]            exec_channel_o,
    output logic                     exec_busy_o,
    input  logic                     exec_done_i
);
    typedef enum logic [1:0] {IDLE, START, RUN} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            chan_q, chan_d;
    logic [CW-1:0]            last_q, last_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]      done_q, done_d;
    logic [CHANNELS-1:0]      tmo_q, tmo_d;
    logic [CHANNELS-1:0]      pending, grant_vec, busy_w;
    logic                     active, grant_vld, expired;
    logic [CW-1:0]            grant_idx;
    logic [TIMEOUT_WIDTH:0]   cnt_inc;

    assign active = (state_q != IDLE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign busy_w[i] = pending[i] | (active && (chan_q == CW'(i)));
        task_dispatcher_chan u_chan (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .req_i     (task_req_i[i]),
            .dis_i     (disable_i[i]),
            .busy_i    (busy_w[i]),
            .grant_i   (grant_vec[i]),
            .pending_o (pending[i])
        );
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            idx = int'(last_q) + 1 + j;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_vld && pending[CW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(idx);
            end
        end
    end

    // Expiry means this RUN cycle is the TIMEOUT_CYCLES-th without done.
    assign cnt_inc = {1'b0, cnt_q} + (TIMEOUT_WIDTH+1)'(1);
    assign expired = (timeout_cycles_i != '0) && (cnt_inc >= {1'b0, timeout_cycles_i});

    // Sequencer next-state: grant, launch, then wait for done or timeout.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        done_d    = '0;
        tmo_d     = '0;
        grant_vec = '0;
        case (state_q)
            IDLE: if (grant_vld) begin
                chan_d               = grant_idx;
                last_d               = grant_idx;
                grant_vec[grant_idx] = 1'b1;
                state_d              = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (exec_done_i) begin
                    done_d[chan_q] = 1'b1;
                    state_d        = IDLE;
                end else if (expired) begin
                    tmo_d[chan_q] = 1'b1;
                    state_d       = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            chan_q  <= '0;
            last_q  <= CW'(CHANNELS - 1);
            cnt_q   <= '0;
            done_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy_o         = busy_w;
    assign task_done_o    = done_q;
    assign task_timeout_o = tmo_q;
    assign exec_start_o   = (state_q == START);
    assign exec_busy_o    = active;
    assign exec_channel_o = chan_q;
endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: each task drives one scenario and
// checks outputs one time unit after the rising edge.
module tb_task_dispatcher;
    localparam int CH = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] task_req = '0;
    logic [CH-1:0] dis = '0;
    logic [TW-1:0] tmo_cycles = '0;
    logic [CH-1:0] busy, task_done, task_timeout;
    logic          exec_start, exec_busy, exec_done = 1'b0;
    logic [1:0]    exec_channel;

    int n_chk = 0;
    int n_fail = 0;

    task_dispatcher #(.CHANNELS(CH), .TIMEOUT_WIDTH(TW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .task_req_i(task_req), .disable_i(dis),
        .timeout_cycles_i(tmo_cycles), .busy_o(busy), .task_done_o(task_done),
        .task_timeout_o(task_timeout), .exec_start_o(exec_start),
        .exec_channel_o(exec_channel), .exec_busy_o(exec_busy), .exec_done_i(exec_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; task_req = '0; dis = '0; exec_done = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Wait (bounded) until exec_start is seen; ok=0 on expiry.
    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        while (!exec_start && n < 12) begin step(); n++; end
        ok = exec_start;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step();
        n_chk++; if (busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0000", busy); end
        n_chk++; if ({task_done, task_timeout} !== 8'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 0", {task_done, task_timeout}); end
        n_chk++; if ({exec_start, exec_busy, exec_channel} !== 4'b0) begin n_fail++; $display("FAIL reset_exec got %b want 0000", {exec_start, exec_busy, exec_channel}); end
        rst_n = 1'b1; step();
    endtask

    task automatic test_single();
        task_req = 4'b0100; step(); task_req = '0;             // cycle 1
        n_chk++; if (busy !== 4'b0100 || exec_start !== 1'b0) begin n_fail++; $display("FAIL single_c1 busy %b start %b want 0100 0", busy, exec_start); end
        step();                                                  // cycle 2
        n_chk++; if (exec_start !== 1'b1 || exec_channel !== 2'd2 || exec_busy !== 1'b1) begin n_fail++; $display("FAIL single_c2 start %b ch %0d ebusy %b want 1 2 1", exec_start, exec_channel, exec_busy); end
        step();                                                  // cycle 3
        n_chk++; if (exec_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width got %b want 0", exec_start); end
        step(); step(); step(); exec_done = 1'b1;                // cycle 6
        n_chk++; if (task_done !== 4'b0 || busy !== 4'b0100) begin n_fail++; $display("FAIL single_c6 done %b busy %b want 0000 0100", task_done, busy); end
        step(); exec_done = 1'b0;                                // cycle 7
        n_chk++; if (task_done !== 4'b0100 || busy !== 4'b0 || exec_busy !== 1'b0) begin n_fail++; $display("FAIL single_c7 done %b busy %b ebusy %b want 0100 0000 0", task_done, busy, exec_busy); end
        step();
        n_chk++; if (task_done !== 4'b0) begin n_fail++; $display("FAIL single_done_width got %b want 0000", task_done); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int ndone;
        logic [CH-1:0] want;
        ndone = 0;
        do_reset();
        task_req = 4'b1111; step(); task_req = '0;
        n_chk++; if (busy !== 4'b1111) begin n_fail++; $display("FAIL rr_busy got %b want 1111", busy); end
        for (int k = 0; k < 4; k++) begin
            wait_start(ok);
            n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_start_timeout grant %0d got none want start", k); end
            n_chk++; if (exec_channel !== 2'(k)) begin n_fail++; $display("FAIL rr_order got %0d want %0d", exec_channel, k); end
            step(); step(); step(); exec_done = 1'b1;
            step(); exec_done = 1'b0;
            want = 4'(1 << k);
            if (task_done === want) ndone++;
            n_chk++; if (task_done !== want) begin n_fail++; $display("FAIL rr_done got %b want %b", task_done, want); end
        end
        n_chk++; if (ndone != 4) begin n_fail++; $display("FAIL rr_done_count got %0d want 4", ndone); end
    endtask

    task automatic test_timeout();
        bit ok;
        tmo_cycles = 16'd5;
        task_req = 4'b0010; step(); task_req = '0;
        wait_start(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo_start got none want start"); end
        for (int i = 0; i < 5; i++) step();                      // s+5
        n_chk++; if (task_timeout !== 4'b0 || exec_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early tmo %b ebusy %b want 0000 1", task_timeout, exec_busy); end
        step();                                                  // s+6
        n_chk++; if (task_timeout !== 4'b0010 || task_done !== 4'b0 || exec_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_fire tmo %b done %b ebusy %b want 0010 0000 0", task_timeout, task_done, exec_busy); end
        step();
        task_req = 4'b0010; step(); task_req = '0;
        wait_start(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo2_start got none want start"); end
        for (int i = 0; i < 5; i++) step();
        exec_done = 1'b1;                                        // done on 5th RUN cycle
        step(); exec_done = 1'b0;
        n_chk++; if (task_done !== 4'b0010 || task_timeout !== 4'b0) begin n_fail++; $display("FAIL tmo_race done %b tmo %b want 0010 0000", task_done, task_timeout); end
        step();
        n_chk++; if (task_timeout !== 4'b0) begin n_fail++; $display("FAIL tmo_late got %b want 0000", task_timeout); end
        tmo_cycles = '0;
    endtask

    task automatic test_no_timeout();
        bit ok;
        bit seen;
        seen = 1'b0;
        task_req = 4'b0001; step(); task_req = '0;
        wait_start(ok);
        for (int i = 0; i < 40; i++) begin step(); if (task_timeout !== 4'b0) seen = 1'b1; end
        n_chk++; if (seen || exec_busy !== 1'b1) begin n_fail++; $display("FAIL notmo seen %b ebusy %b want 0 1", seen, exec_busy); end
        exec_done = 1'b1; step(); exec_done = 1'b0;
        n_chk++; if (task_done !== 4'b0001) begin n_fail++; $display("FAIL notmo_done got %b want 0001", task_done); end
        step();
    endtask

    task automatic test_busy_disable();
        int nd;
        bit bad;
        nd = 0; bad = 1'b0;
        task_req = 4'b0010;                                      // cycle 0
        for (int c = 1; c <= 12; c++) begin
            step();
            if (task_done[1] === 1'b1) nd++;
            task_req  = (c <= 5) ? 4'b0010 : 4'b0000;
            exec_done = (c == 5);
        end
        task_req = '0; exec_done = 1'b0;
        n_chk++; if (nd != 1) begin n_fail++; $display("FAIL busy_repeat done_count got %0d want 1", nd); end
        n_chk++; if (busy !== 4'b0 || exec_busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle busy %b ebusy %b want 0000 0", busy, exec_busy); end
        task_req = 4'b0001; step(); task_req = '0;               // c1
        step(); step();                                          // c3 RUN ch0
        task_req = 4'b1000; step(); task_req = '0;               // c4
        n_chk++; if (busy !== 4'b1001) begin n_fail++; $display("FAIL dis_pending got %b want 1001", busy); end
        dis = 4'b1000; step(); dis = '0;                         // c5
        n_chk++; if (busy !== 4'b0001) begin n_fail++; $display("FAIL dis_flush got %b want 0001", busy); end
        exec_done = 1'b1; step(); exec_done = 1'b0;              // c6
        n_chk++; if (task_done !== 4'b0001) begin n_fail++; $display("FAIL dis_done got %b want 0001", task_done); end
        task_req = 4'b1000; dis = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            step(); task_req = '0; dis = '0;
            if (exec_start === 1'b1 || busy[3] === 1'b1) bad = 1'b1;
        end
        n_chk++; if (bad) begin n_fail++; $display("FAIL dis_grant got start_or_busy3 want none"); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit seen;
        seen = 1'b0;
        task_req = 4'b0010; step(); task_req = '0;
        wait_start(ok);
        step(); step();
        n_chk++; if (exec_busy !== 1'b1 || exec_channel !== 2'd1) begin n_fail++; $display("FAIL mid_run ebusy %b ch %0d want 1 1", exec_busy, exec_channel); end
        rst_n = 1'b0; #1;
        n_chk++; if ({busy, task_done, task_timeout, exec_start, exec_busy, exec_channel} !== 16'b0) begin n_fail++; $display("FAIL mid_reset_outputs got %b want 0", {busy, task_done, task_timeout, exec_start, exec_busy, exec_channel}); end
        exec_done = 1'b1; step(); exec_done = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin step(); if (task_done !== 4'b0 || task_timeout !== 4'b0) seen = 1'b1; end
        n_chk++; if (seen) begin n_fail++; $display("FAIL mid_reset_pulse got pulse want none"); end
        task_req = 4'b0011; step(); task_req = '0;
        n_chk++; if (busy !== 4'b0011) begin n_fail++; $display("FAIL post_reset_busy got %b want 0011", busy); end
        step();
        n_chk++; if (exec_start !== 1'b1 || exec_channel !== 2'd0) begin n_fail++; $display("FAIL post_reset_grant start %b ch %0d want 1 0", exec_start, exec_channel); end
        step(); exec_done = 1'b1; step(); exec_done = 1'b0;
        wait_start(ok);
        n_chk++; if (!ok || exec_channel !== 2'd1) begin n_fail++; $display("FAIL post_reset_second ok %b ch %0d want 1 1", ok, exec_channel); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_no_timeout();
        test_busy_disable();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
